// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: buffers 128-bit AES ciphertext blocks in a small FIFO and
// streams them out as 32-bit words, most significant word first, over a
// valid/ready handshake. The AES core cannot be stalled, so a block that
// arrives while the buffer is full is dropped and a sticky overflow flag is set.
// All outputs come straight from registers; nothing on the output side depends
// combinationally on valid or out_ready.
module aes_ct_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             C,
    input  logic                     valid,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    // Block storage; contents need no reset because level says what is valid.
    logic [127:0]     mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [1:0]       word_idx_r;
    logic [LVL_W-1:0] level_r;
    logic [31:0]      out_data_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic             overflow_r;

    logic             pop_s;
    logic             pop_blk_s;
    logic             full_s;
    logic             accept_s;
    logic             drop_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [1:0]       word_idx_nxt_s;
    logic [LVL_W-1:0] level_nxt_s;
    logic             overflow_nxt_s;
    logic [127:0]     head_blk_s;
    logic [31:0]      out_data_nxt_s;
    logic             out_valid_nxt_s;
    logic             out_last_nxt_s;

    // Word select: index 0 is the most significant word of the block.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Handshake decode, write/drop decisions and next-state of every register.
    always_comb begin
        pop_s          = out_valid_r & out_ready;
        pop_blk_s      = pop_s & (word_idx_r == 2'd3);
        full_s         = (level_r == LVL_W'(DEPTH));
        accept_s       = valid & (~full_s | pop_blk_s);
        drop_s         = valid & full_s & ~pop_blk_s;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        word_idx_nxt_s = word_idx_r;
        level_nxt_s    = level_r;
        overflow_nxt_s = overflow_r;
        head_blk_s     = 128'h0;
        out_data_nxt_s = 32'h0000_0000;
        out_valid_nxt_s = 1'b0;
        out_last_nxt_s = 1'b0;

        if (accept_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_blk_s) begin
            word_idx_nxt_s = 2'd0;
            rd_ptr_nxt_s   = rd_ptr_r + PTR_W'(1);
        end else if (pop_s) begin
            word_idx_nxt_s = word_idx_r + 2'd1;
        end else begin
            word_idx_nxt_s = word_idx_r;
        end

        case ({accept_s, pop_blk_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end

        // The next head block may be the one being written this very edge
        // (buffer empty, or last block draining while a new one lands).
        if (accept_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_blk_s = C;
        end else begin
            head_blk_s = mem_r[rd_ptr_nxt_s];
        end

        if (level_nxt_s != LVL_W'(0)) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = word_sel(head_blk_s, word_idx_nxt_s);
            out_last_nxt_s  = (word_idx_nxt_s == 2'd3);
        end else begin
            out_valid_nxt_s = 1'b0;
            out_data_nxt_s  = 32'h0000_0000;
            out_last_nxt_s  = 1'b0;
        end
    end

    // Block storage write on accept.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= C;
        end
    end

    // Pointers, level, flags and the registered output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            word_idx_r  <= 2'd0;
            level_r     <= '0;
            out_data_r  <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            word_idx_r  <= word_idx_nxt_s;
            level_r     <= level_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Bench for aes_ct_serializer: directed scenarios followed by random traffic,
// every output compared each cycle against a queue-based model of the buffer.
module tb_aes_ct_serializer;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [127:0]     C = 128'h0;
    logic             valid = 1'b0;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: ordered list of held blocks, word position in the head, flag.
    logic [127:0] q [$];
    int           m_widx = 0;
    logic         m_ovf = 1'b0;

    logic [127:0] blk_a = 128'h3925841d02dc09fbdc118597196a0b32;
    logic [127:0] rnd;

    aes_ct_serializer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .C        (C),
        .valid    (valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [127:0] h;
        logic [31:0]  exp_data;
        logic         exp_valid;
        logic         exp_last;
        exp_valid = (q.size() != 0);
        exp_data  = 32'h0;
        exp_last  = 1'b0;
        if (exp_valid) begin
            h        = q[0];
            exp_data = 32'(h >> (32 * (3 - m_widx)));
            exp_last = (m_widx == 3);
        end
        chk("out_valid", {127'h0, out_valid}, {127'h0, exp_valid});
        chk("out_data",  {96'h0, out_data},   {96'h0, exp_data});
        chk("out_last",  {127'h0, out_last},  {127'h0, exp_last});
        chk("level",     128'(level),         128'(q.size()));
        chk("overflow",  {127'h0, overflow},  {127'h0, m_ovf});
    endtask

    // One clock cycle: drive inputs, check current outputs, advance the model.
    task automatic cycle(input logic v, input logic [127:0] c, input logic rdy, input logic clr);
        logic pop;
        logic pop_blk;
        logic acc;
        valid     = v;
        C         = c;
        out_ready = rdy;
        clr_ovf   = clr;
        #1;
        check_outputs();
        @(posedge clk);
        pop     = (q.size() != 0) && rdy;
        pop_blk = pop && (m_widx == 3);
        acc     = v && ((q.size() < DEPTH) || pop_blk);
        if (pop_blk) begin
            void'(q.pop_front());
            m_widx = 0;
        end else if (pop) begin
            m_widx++;
        end
        if (acc) q.push_back(c);
        if (v && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 128'h0, rdy, 1'b0);
    endtask

    function automatic logic [127:0] mk_blk(input int k);
        return {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k),
                32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)};
    endfunction

    initial begin
        // Reset state while held in reset.
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single block, consumer always ready.
        cycle(1'b1, blk_a, 1'b1, 1'b0);
        chk("first_word", {96'h0, out_data}, {96'h0, 32'h3925841d});
        idle(5, 1'b1);

        // Backpressure pattern on the same block.
        cycle(1'b1, blk_a, 1'b0, 1'b0);
        cycle(1'b0, 128'h0, 1'b1, 1'b0);
        cycle(1'b0, 128'h0, 1'b0, 1'b0);
        cycle(1'b0, 128'h0, 1'b0, 1'b0);
        cycle(1'b0, 128'h0, 1'b1, 1'b0);
        cycle(1'b0, 128'h0, 1'b0, 1'b0);
        cycle(1'b0, 128'h0, 1'b1, 1'b1);
        cycle(1'b0, 128'h0, 1'b1, 1'b0);
        chk("bp_drained", 128'(level), 128'd0);

        // Fill with five blocks while stalled: the fifth is dropped.
        for (int k = 1; k <= 5; k++) cycle(1'b1, mk_blk(k), 1'b0, 1'b0);
        chk("fill_level", 128'(level), 128'd4);
        chk("fill_ovf", {127'h0, overflow}, 128'd1);
        idle(17, 1'b1);
        cycle(1'b0, 128'h0, 1'b0, 1'b1);
        chk("clr_ovf", {127'h0, overflow}, 128'd0);

        // Full buffer accepts when the final word pops in the same cycle.
        for (int k = 11; k <= 14; k++) cycle(1'b1, mk_blk(k), 1'b0, 1'b0);
        idle(3, 1'b1);
        cycle(1'b1, mk_blk(15), 1'b1, 1'b0);
        chk("fullpop_level", 128'(level), 128'd4);
        chk("fullpop_ovf", {127'h0, overflow}, 128'd0);
        idle(17, 1'b1);

        // Clear and drop in the same cycle: set wins.
        for (int k = 21; k <= 24; k++) cycle(1'b1, mk_blk(k), 1'b0, 1'b0);
        cycle(1'b1, mk_blk(25), 1'b0, 1'b1);
        chk("clr_drop_ovf", {127'h0, overflow}, 128'd1);

        // Reset mid-stream: three blocks held, head at word 2, overflow set.
        idle(6, 1'b1);
        chk("pre_rst_level", 128'(level), 128'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {127'h0, out_valid}, 128'd0);
        chk("rst_level", 128'(level), 128'd0);
        chk("rst_overflow", {127'h0, overflow}, 128'd0);
        chk("rst_out_data", {96'h0, out_data}, 128'd0);
        q.delete();
        m_widx = 0;
        m_ovf  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, mk_blk(31), 1'b0, 1'b0);
        chk("post_rst_word0", {96'h0, out_data}, {96'h0, 32'hA000_001F});
        idle(5, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            cycle(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end
        idle(20, 1'b1);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
- Downstream stage of the pipelined AES core.
- Captures each 128-bit ciphertext block C whenever the core pulses valid, and buffers the blocks in a small FIFO.
- Emits the blocks as a 32-bit word stream with a valid/ready handshake, most significant word first, for the bus/host interface.
- The core cannot be stalled, so blocks that arrive while the buffer is full are dropped and flagged.

Parameters:
- DEPTH, 4, number of 128-bit blocks buffered; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1, width of the level output (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- C  input  128  ciphertext block from the AES core.
- valid  input  1  C is valid this cycle; single-cycle qualifier, may be high on consecutive cycles.
- out_data  output  32  current word of the head block.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_last  output  1  out_data is word 3 (last) of its block.
- level  output  LVL_W  number of blocks held, including a partially drained head block.
- overflow  output  1  sticky: at least one block was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, asynchronous), all of the following forced regardless of clk:
  - wr_ptr, rd_ptr, word_idx, level = 0.
  - out_valid = 0, out_last = 0, overflow = 0, out_data = 0.
  - Buffer contents are don't-care.
  - Reset mid-stream discards all buffered and partially drained blocks. After release, the first block captured is the first block output.
- Definitions:
  - pop = out_valid & out_ready.
  - pop_blk = pop & (word_idx == 3).
  - full = (level == DEPTH).
  - empty = (level == 0).
- Write:
  - accept = valid & (~full | pop_blk).
  - On accept, store C at wr_ptr; wr_ptr increments modulo DEPTH.
  - A simultaneous final-word pop frees the slot in the same edge, so a full buffer still accepts.
- Drop:
  - valid & full & ~pop_blk → block discarded; overflow <= 1.
  - If clr_ovf and a drop occur in the same cycle, overflow ends at 1 (set wins).
  - Otherwise clr_ovf=1 → overflow <= 0.
- Read:
  - out_valid = ~empty, registered state, no combinational path from valid or out_ready.
  - out_data selects from the head block by word_idx: 0 → C[127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0].
  - out_last = out_valid & (word_idx == 3).
  - On pop, word_idx increments. On pop_blk, word_idx wraps to 0 and rd_ptr increments modulo DEPTH.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - When empty, out_data = 0.
- Level:
  - level <= level + accept − pop_blk.
  - Accept and pop_blk in the same cycle leave level unchanged.
  - level never exceeds DEPTH and never underflows.
- Latency:
  - A block captured at edge N gives out_valid=1 after edge N when the buffer was empty.
  - Its first word can be popped at edge N+1.
- Throughput: one word per cycle when out_ready is held high; one block per 4 cycles sustained.
- Pointer wrap: wr_ptr and rd_ptr wrap at DEPTH; full and empty are distinguished by level, not pointer equality.
- Not a stage: out_ready while out_valid=0 has no effect.

Test Plan:
- Single block, C=3925841d02dc09fbdc118597196a0b32 with valid for one cycle, out_ready=1:
  - out_valid rises after the capture edge.
  - Words in order: 3925841d, 02dc09fb, dc118597, 196a0b32, with out_last only on 196a0b32.
  - level goes 1 → 0 after the 4th pop; overflow=0.
- Backpressure, same block with out_ready toggled 1,0,0,1,0,1,1:
  - Each word is held stable while out_ready=0; no word is repeated or skipped; 4 pops total.
- Fill, out_ready=0, 5 distinct blocks on consecutive cycles:
  - level=4, overflow=1, 5th block absent.
  - Draining yields blocks 1–4 in order.
  - Pulsing clr_ovf then clears overflow to 0.
- Full with simultaneous pop:
  - Setup: level=4, head at word_idx=3, out_ready=1, valid=1 with a new block in the same cycle.
  - Required: block accepted, level stays 4, overflow stays 0, new block emerges last.
- clr_ovf and drop in the same cycle → overflow remains 1.
- Reset mid-stream:
  - Setup: 3 blocks buffered, head at word_idx=2.
  - Pull rst=0 asynchronously between edges: out_valid, level and overflow go to 0 immediately.
  - After release, the next captured block is output starting at word 0.
